// File: rtl/kmeans_pkg.sv
// Shared k-means definitions: FSM state encoding,
// status word bit positions and a width helper.
package kmeans_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ACC  = 4'b0010,
        DIV  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    localparam int ST_STATE_LSB = 0;
    localparam int ST_STATE_W   = 4;
    localparam int ST_OVF_BIT   = 8;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/centroid_update_if.sv
// Point/centroid bus between the assignment stage
// and the centroid update block.
interface centroid_update_if
    import kmeans_pkg::*;
#(
    parameter int DW       = 8,
    parameter int CLUSTERS = 2,
    parameter int PARAMS   = 13
);
    localparam int CW = clog2_min1(CLUSTERS);
    localparam int CV = CLUSTERS * PARAMS * DW;

    logic                   enable_i;
    logic                   update_i;
    logic [PARAMS*DW-1:0]   data_i;
    logic [CW-1:0]          cluster_i;
    logic                   assign_valid_i;
    logic [CV-1:0]          centroid_i;
    logic [CV-1:0]          centroid_o;
    logic                   centroid_valid_o;
    logic                   changed_o;
    logic [31:0]            status_o;

    modport master (
        output enable_i, update_i, data_i, cluster_i,
        output assign_valid_i, centroid_i,
        input  centroid_o, centroid_valid_o, changed_o,
        input  status_o
    );

    modport slave (
        input  enable_i, update_i, data_i, cluster_i,
        input  assign_valid_i, centroid_i,
        output centroid_o, centroid_valid_o, changed_o,
        output status_o
    );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Quotient output is valid while done_o is high.
module seq_divider #(
    parameter int SW    = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic [SW-1:0]    dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [SW-1:0]    quotient_o
);
    localparam int KW = $clog2(SW + 1);

    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] dvs;
    logic [SW-1:0]    quo;
    logic [KW-1:0]    cnt;
    logic             busy;
    logic [CNT_W:0]   shifted;
    logic [CNT_W:0]   diff;
    logic             take;
    logic [CNT_W-1:0] rem_nx;
    logic [SW-1:0]    quo_nx;

    // one restoring step: shift in next dividend bit, try subtract
    always_comb begin
        shifted = {rem, quo[SW-1]};
        diff    = shifted - {1'b0, dvs};
        take    = shifted >= {1'b0, dvs};
        rem_nx  = take ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
        quo_nx  = {quo[SW-2:0], take};
    end

    // load on start, then iterate SW times
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start_i) begin
            rem  <= '0;
            dvs  <= divisor_i;
            quo  <= dividend_i;
            cnt  <= KW'(SW);
            busy <= 1'b1;
        end else if (busy) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - 1'b1;
            if (cnt == KW'(1)) busy <= 1'b0;
        end
    end

    assign busy_o     = busy;
    assign done_o     = busy && (cnt == KW'(1));
    assign quotient_o = quo_nx;

endmodule

// File: rtl/centroid_update.sv
// Accumulates per-cluster feature sums during an epoch,
// then divides element by element into new centroids.
module centroid_update
    import kmeans_pkg::*;
#(
    parameter int DW       = 8,
    parameter int CLUSTERS = 2,
    parameter int PARAMS   = 13,
    parameter int CNT_W    = 16
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    centroid_update_if.slave bus
);
    localparam int SW = DW + CNT_W;
    localparam int CW = clog2_min1(CLUSTERS);
    localparam int PW = clog2_min1(PARAMS);
    localparam int CV = CLUSTERS * PARAMS * DW;

    state_t           state;
    state_t           state_nx;
    logic [SW-1:0]    sums   [CLUSTERS][PARAMS];
    logic [CNT_W-1:0] counts [CLUSTERS];
    logic             ovf;
    logic [CW-1:0]    cl;
    logic [PW-1:0]    pr;
    logic [DW-1:0]    res    [CLUSTERS][PARAMS];
    logic [DW-1:0]    cent_hold;
    logic [CV-1:0]    res_flat;
    logic [DW-1:0]    mean;
    logic [31:0]      status;
    logic             start;
    logic             busy;
    logic             done;
    logic             last;
    logic [SW-1:0]    quot;

    seq_divider #(.SW(SW), .CNT_W(CNT_W)) u_div (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .start_i    (start),
        .dividend_i (sums[cl][pr]),
        .divisor_i  (counts[cl]),
        .busy_o     (busy),
        .done_o     (done),
        .quotient_o (quot)
    );

    // state register
    always_ff @(posedge clk_i) begin
        if (!resetn_i) state <= IDLE;
        else           state <= state_nx;
    end

    // next state and divider issue
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        last     = (cl == CW'(CLUSTERS - 1)) &&
                   (pr == PW'(PARAMS - 1));
        unique case (state)
            IDLE: if (bus.enable_i) state_nx = ACC;
            ACC:  if (bus.update_i) state_nx = DIV;
            DIV: begin
                start = !busy;
                if (done && last) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // per-cluster sums and counts, saturating count drops samples
    always_ff @(posedge clk_i) begin
        if (!resetn_i || (state == IDLE && bus.enable_i)) begin
            ovf <= 1'b0;
            for (int c = 0; c < CLUSTERS; c++) begin
                counts[c] <= '0;
                for (int p = 0; p < PARAMS; p++) sums[c][p] <= '0;
            end
        end else if (state == ACC && bus.assign_valid_i) begin
            for (int c = 0; c < CLUSTERS; c++) begin
                if (bus.cluster_i == CW'(c)) begin
                    if (counts[c] == '1) begin
                        ovf <= 1'b1;
                    end else begin
                        counts[c] <= counts[c] + 1'b1;
                        for (int p = 0; p < PARAMS; p++)
                            sums[c][p] <= sums[c][p] +
                                SW'(bus.data_i[p*DW +: DW]);
                    end
                end
            end
        end
    end

    // quotient never exceeds DW bits; clamp keeps all bits meaningful
    always_comb begin
        mean = (quot[SW-1:DW] != '0) ? '1 : quot[DW-1:0];
    end

    // element walk: sample centroid on issue, store result on done
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cl        <= '0;
            pr        <= '0;
            cent_hold <= '0;
            for (int c = 0; c < CLUSTERS; c++)
                for (int p = 0; p < PARAMS; p++) res[c][p] <= '0;
        end else if (state == DIV) begin
            if (start)
                cent_hold <= bus.centroid_i[
                    (int'(cl) * PARAMS + int'(pr)) * DW +: DW];
            if (done) begin
                res[cl][pr] <= (counts[cl] == '0) ? cent_hold : mean;
                if (pr == PW'(PARAMS - 1)) begin
                    pr <= '0;
                    cl <= cl + 1'b1;
                end else begin
                    pr <= pr + 1'b1;
                end
            end
        end else begin
            cl <= '0;
            pr <= '0;
        end
    end

    // pack results in centroid_i order
    always_comb begin
        res_flat = '0;
        for (int c = 0; c < CLUSTERS; c++)
            for (int p = 0; p < PARAMS; p++)
                res_flat[(c*PARAMS + p)*DW +: DW] = res[c][p];
    end

    // publish results and change flag when leaving DONE
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            bus.centroid_o       <= '0;
            bus.centroid_valid_o <= 1'b0;
            bus.changed_o        <= 1'b0;
        end else begin
            bus.centroid_valid_o <= (state == DONE);
            if (state == DONE) begin
                bus.centroid_o <= res_flat;
                bus.changed_o  <= (res_flat != bus.centroid_i);
            end
        end
    end

    // status word: one-hot state plus sticky overflow
    always_comb begin
        status = '0;
        status[ST_STATE_LSB +: ST_STATE_W] = state;
        status[ST_OVF_BIT] = ovf;
    end

    assign bus.status_o = status;

endmodule
